// File: rtl/wave_osc_gen.sv
// wave_osc_gen: phase-accumulator oscillator (square/saw/triangle/mute), config applied at phase wrap.
// Optional WAVE_OSC_AMP_EN adds an 8-bit output gain stage (one extra cycle of latency).
module wave_osc_gen #(
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16,
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_step,
  input  logic [DUTY_W-1:0] cfg_duty,
  input  logic [1:0]        cfg_mode,
`ifdef WAVE_OSC_AMP_EN
  input  logic [7:0]        amp,
`endif
  output logic [OUT_W-1:0]  wave_out,
  output logic              out_valid,
  output logic              wrap
);
  typedef enum logic {IDLE, PENDING} state_e;
  state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, step_q, step_sh_q;
  logic [DUTY_W-1:0] duty_q, duty_sh_q, t;
  logic [1:0] mode_q, mode_sh_q;
  logic [ACC_W:0] sum;
  logic [OUT_W-1:0] p, q, sq, saw, tri_w, smp_d;
  logic wrap_ev, capture, xfer;
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, step_q};
    wrap_ev = sync | (enable & sum[ACC_W]);
    acc_d = sync ? '0 : enable ? sum[ACC_W-1:0] : acc_q;
    cfg_ready = state_q == IDLE;
    capture = cfg_ready & cfg_valid;
    xfer = (state_q == PENDING) & (wrap_ev | ~enable);
    state_d = capture ? PENDING : xfer ? IDLE : state_q;
  end
  always_comb begin
    p = acc_q[ACC_W-1 -: OUT_W];
    t = acc_q[ACC_W-1 -: DUTY_W];
    q = p[OUT_W-1] ? ~(p << 1) : (p << 1);
    sq = (t < duty_q) ? {1'b0, {(OUT_W-1){1'b1}}} : {1'b1, {(OUT_W-1){1'b0}}};
    saw = {~p[OUT_W-1], p[OUT_W-2:0]};
    tri_w = {~q[OUT_W-1], q[OUT_W-2:0]};
    smp_d = mode_q == 2'b00 ? sq : mode_q == 2'b01 ? saw : mode_q == 2'b10 ? tri_w : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      step_q    <= '0;
      duty_q    <= {1'b1, {(DUTY_W-1){1'b0}}};
      mode_q    <= 2'b00;
      step_sh_q <= '0;
      duty_sh_q <= '0;
      mode_sh_q <= 2'b00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (capture) begin
        step_sh_q <= cfg_step;
        duty_sh_q <= cfg_duty;
        mode_sh_q <= cfg_mode;
      end
      if (xfer) begin
        step_q <= step_sh_q;
        duty_q <= duty_sh_q;
        mode_q <= mode_sh_q;
      end
    end
  end
`ifdef WAVE_OSC_AMP_EN
  localparam int LAT = 2;
  logic [7:0] amp_q, amp_sh_q, amp_p_q;
  logic [OUT_W-1:0] smp_q;
  logic signed [OUT_W+8:0] prod;
  // Gain travels with its sample so a config change never scales an old-period sample.
  always_comb prod = $signed({{9{smp_q[OUT_W-1]}}, smp_q}) * $signed({{(OUT_W+1){1'b0}}, amp_p_q});
  always_ff @(posedge clk) begin
    if (reset) begin
      amp_q    <= 8'hFF;
      amp_sh_q <= 8'hFF;
      amp_p_q  <= 8'hFF;
      smp_q    <= '0;
      wave_out <= '0;
    end else begin
      if (capture) amp_sh_q <= amp;
      if (xfer) amp_q <= amp_sh_q;
      amp_p_q  <= amp_q;
      smp_q    <= smp_d;
      wave_out <= amp_p_q == 8'hFF ? smp_q : prod[OUT_W+7:8];
    end
  end
`else
  localparam int LAT = 1;
  always_ff @(posedge clk) wave_out <= reset ? '0 : smp_d;
`endif
  // Wrap is delayed to line up with the first sample computed from the new-period phase.
  logic [LAT:0] wp_q, vld_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      vld_q <= '0;
    end else begin
      wp_q  <= {wp_q[LAT-1:0], wrap_ev};
      vld_q <= {vld_q[LAT-1:0], 1'b1};
    end
  end
  assign wrap = wp_q[LAT];
  assign out_valid = vld_q[LAT];
endmodule

// File: tb/tb_wave_osc_gen.sv
// tb_wave_osc_gen: vector table, directed handshake/sync/reset sequences and a random run against a cycle model.
module tb_wave_osc_gen;
  logic clk = 0, reset = 1, enable = 0, sync = 0, cfg_valid = 0;
  logic cfg_ready, out_valid, wrap;
  logic [15:0] cfg_step = 0, wave_out;
  logic [7:0] cfg_duty = 0;
  logic [1:0] cfg_mode = 0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  wave_osc_gen #(.ACC_W(16), .OUT_W(16), .DUTY_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_step(cfg_step),
    .cfg_duty(cfg_duty), .cfg_mode(cfg_mode), .wave_out(wave_out),
    .out_valid(out_valid), .wrap(wrap)
  );

  int m_phase = 0, m_step = 0, m_duty = 128, m_mode = 0, s_step = 0, s_duty = 0, s_mode = 0, m_nrst = 0;
  bit m_pend = 0, m_wev = 0, e_wrap = 0, e_valid = 0, e_ready = 1;
  logic [15:0] e_wave = 0;

  function automatic logic [15:0] ref_sample(int ph, int mode, int duty);
    int v;
    if (mode == 0) v = ((ph >> 8) < duty) ? 32767 : -32768;
    else if (mode == 1) v = ph - 32768;
    else if (mode == 2) v = (ph < 32768) ? 2 * ph - 32768 : 98303 - 2 * ph;
    else v = 0;
    return v[15:0];
  endfunction

  task automatic model_edge();
    int s;
    bit wev;
    if (reset) begin
      m_phase = 0; m_step = 0; m_duty = 128; m_mode = 0; m_pend = 0;
      m_wev = 0; m_nrst = 0; e_wave = 0; e_wrap = 0; e_valid = 0;
    end else begin
      e_wave = ref_sample(m_phase, m_mode, m_duty);
      e_wrap = m_wev;
      s = m_phase + m_step;
      wev = sync || (enable && s >= 65536);
      if (m_pend && (wev || !enable)) begin
        m_step = s_step; m_duty = s_duty; m_mode = s_mode; m_pend = 0;
      end else if (!m_pend && cfg_valid) begin
        s_step = int'(cfg_step); s_duty = int'(cfg_duty); s_mode = int'(cfg_mode); m_pend = 1;
      end
      m_phase = sync ? 0 : enable ? s % 65536 : m_phase;
      m_wev = wev;
      m_nrst++;
      e_valid = m_nrst >= 2;
    end
    e_ready = !m_pend;
  endtask

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model.wave", wave_out, e_wave);
    chk("model.wrap", {15'd0, wrap}, {15'd0, e_wrap});
    chk("model.valid", {15'd0, out_valid}, {15'd0, e_valid});
    chk("model.ready", {15'd0, cfg_ready}, {15'd0, e_ready});
  endtask

  task automatic start(logic [1:0] mode, logic [15:0] step, logic [7:0] duty);
    reset = 1; enable = 0; sync = 0; cfg_valid = 0;
    tick();
    reset = 0; cfg_valid = 1; cfg_mode = mode; cfg_step = step; cfg_duty = duty;
    tick();
    cfg_valid = 0;
    tick();
    enable = 1;
  endtask

  typedef struct {
    logic [1:0] mode; logic [15:0] step; logic [7:0] duty; int k; logic [15:0] wave; logic wr;
  } vec_t;
  vec_t vt[$];

  initial begin
    int n;
    tick();
    chk("reset.wave", wave_out, 16'h0000);
    chk("reset.wrap", {15'd0, wrap}, 16'd0);
    chk("reset.valid", {15'd0, out_valid}, 16'd0);
    chk("reset.ready", {15'd0, cfg_ready}, 16'd1);

    vt.push_back('{2'd0, 16'h0100, 8'h40, 1,   16'h7FFF, 1'b0});
    vt.push_back('{2'd0, 16'h0100, 8'h40, 64,  16'h7FFF, 1'b0});
    vt.push_back('{2'd0, 16'h0100, 8'h40, 65,  16'h8000, 1'b0});
    vt.push_back('{2'd0, 16'h0100, 8'h40, 256, 16'h8000, 1'b0});
    vt.push_back('{2'd0, 16'h0100, 8'h40, 257, 16'h7FFF, 1'b1});
    vt.push_back('{2'd0, 16'h0100, 8'h40, 258, 16'h7FFF, 1'b0});
    vt.push_back('{2'd0, 16'h0100, 8'h00, 1,   16'h8000, 1'b0});
    vt.push_back('{2'd0, 16'h0100, 8'hFF, 255, 16'h7FFF, 1'b0});
    vt.push_back('{2'd0, 16'h0100, 8'hFF, 256, 16'h8000, 1'b0});
    vt.push_back('{2'd1, 16'h1000, 8'h40, 1,   16'h8000, 1'b0});
    vt.push_back('{2'd1, 16'h1000, 8'h40, 2,   16'h9000, 1'b0});
    vt.push_back('{2'd1, 16'h1000, 8'h40, 16,  16'h7000, 1'b0});
    vt.push_back('{2'd1, 16'h1000, 8'h40, 17,  16'h8000, 1'b1});
    vt.push_back('{2'd2, 16'h2000, 8'h40, 1,   16'h8000, 1'b0});
    vt.push_back('{2'd2, 16'h2000, 8'h40, 2,   16'hC000, 1'b0});
    vt.push_back('{2'd2, 16'h2000, 8'h40, 3,   16'h0000, 1'b0});
    vt.push_back('{2'd2, 16'h2000, 8'h40, 4,   16'h4000, 1'b0});
    vt.push_back('{2'd2, 16'h2000, 8'h40, 5,   16'h7FFF, 1'b0});
    vt.push_back('{2'd2, 16'h2000, 8'h40, 6,   16'h3FFF, 1'b0});
    vt.push_back('{2'd2, 16'h2000, 8'h40, 7,   16'hFFFF, 1'b0});
    vt.push_back('{2'd2, 16'h2000, 8'h40, 8,   16'hBFFF, 1'b0});
    vt.push_back('{2'd2, 16'h2000, 8'h40, 9,   16'h8000, 1'b1});
    vt.push_back('{2'd3, 16'h1000, 8'h40, 5,   16'h0000, 1'b0});
    foreach (vt[i]) begin
      start(vt[i].mode, vt[i].step, vt[i].duty);
      repeat (vt[i].k) tick();
      chk($sformatf("vec%0d.wave", i), wave_out, vt[i].wave);
      chk($sformatf("vec%0d.wrap", i), {15'd0, wrap}, {15'd0, vt[i].wr});
    end

    // Mid-period reconfiguration waits for the wrap, then the period halves.
    start(2'd0, 16'h0100, 8'h40);
    repeat (10) tick();
    cfg_valid = 1; cfg_step = 16'h0200; cfg_mode = 2'd1;
    tick();
    chk("hs.ready_drop", {15'd0, cfg_ready}, 16'd0);
    cfg_step = 16'h0700;
    tick();
    cfg_valid = 0;
    n = 0;
    while (!cfg_ready && n < 300) begin tick(); n++; end
    chk("hs.ready_timeout", {15'd0, cfg_ready}, 16'd1);
    tick();
    chk("hs.wrap", {15'd0, wrap}, 16'd1);
    chk("hs.first", wave_out, 16'h8000);
    n = 0;
    do begin tick(); n++; end while (!wrap && n < 300);
    chk("hs.period", 16'(n), 16'd128);

    // sync at phase 0x5A00 restarts the period and applies the pending config.
    start(2'd0, 16'h0100, 8'h40);
    repeat (20) tick();
    cfg_valid = 1; cfg_step = 16'h0400; cfg_mode = 2'd1;
    tick();
    cfg_valid = 0;
    chk("sync.pending", {15'd0, cfg_ready}, 16'd0);
    n = 0;
    while (m_phase != 32'h5A00 && n < 300) begin tick(); n++; end
    chk("sync.reach", 16'(m_phase), 16'h5A00);
    sync = 1;
    tick();
    sync = 0;
    chk("sync.ready", {15'd0, cfg_ready}, 16'd1);
    tick();
    chk("sync.wrap", {15'd0, wrap}, 16'd1);
    chk("sync.wave0", wave_out, 16'h8000);
    tick();
    chk("sync.wave1", wave_out, 16'h8400);

    // Reset with a pending config discards it.
    start(2'd0, 16'h0100, 8'h40);
    repeat (30) tick();
    cfg_valid = 1; cfg_step = 16'h0300; cfg_mode = 2'd2;
    tick();
    cfg_valid = 0;
    reset = 1;
    tick();
    chk("rst.wave", wave_out, 16'h0000);
    chk("rst.wrap", {15'd0, wrap}, 16'd0);
    chk("rst.valid", {15'd0, out_valid}, 16'd0);
    chk("rst.ready", {15'd0, cfg_ready}, 16'd1);
    reset = 0; enable = 1;
    repeat (3) tick();
    chk("rst.after_wave", wave_out, 16'h7FFF);
    chk("rst.after_valid", {15'd0, out_valid}, 16'd1);

    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 199) == 0;
      enable = $urandom_range(0, 9) < 8;
      sync = $urandom_range(0, 49) == 0;
      cfg_valid = $urandom_range(0, 4) == 0;
      cfg_step = $urandom_range(0, 1) ? 16'($urandom_range(0, 4095)) : 16'($urandom);
      cfg_duty = 8'($urandom);
      cfg_mode = 2'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
